// File: rtl/uart_pkt_pkg.sv
// uart_pkt_pkg: shared constants for the UART packetizer.
// Parity-mode encoding, FSM state encoding, parity helper.
package uart_pkt_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;
  localparam logic [1:0] PAR_RSVD = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } st_e;

  // Reserved mode behaves like no parity.
  function automatic logic par_enabled(logic [1:0] m);
    return (m == PAR_EVEN) || (m == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_pkt_fifo.sv
// uart_pkt_fifo: synchronous FIFO, push/pop same cycle allowed.
// Ports: clk, rst_n, push_i/wdata_i, pop_i/rdata_o, full_o, empty_o, level_o.
module uart_pkt_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [LW-1:0]    level_q;
  logic             do_push, do_pop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem[rptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_packetizer_param.sv
// uart_packetizer_param: AXI-stream words -> FIFO -> UART frames,
// optional parity, 1/2 stop bits, optional XOR checksum frame per packet.
// Ports: clk, rst_n, s_axis_* (in), cfg_* (frame format), tx_ready,
// serial_out, tx_busy, fifo_full/empty/level.
module uart_packetizer_param
  import uart_pkt_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [DATA_BITS-1:0]        s_axis_tdata,
  input  logic                        s_axis_tvalid,
  input  logic                        s_axis_tlast,
  output logic                        s_axis_tready,
  input  logic [1:0]                  cfg_parity,
  input  logic                        cfg_stop2,
  input  logic                        cfg_chk_en,
  input  logic                        tx_ready,
  output logic                        serial_out,
  output logic                        tx_busy,
  output logic                        fifo_full,
  output logic                        fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int DIV = CLK_FREQ / BAUD_RATE;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW  = $clog2(DATA_BITS + 1);

  st_e                  state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] chk_q, chk_d;
  logic                 chk_pend_q, chk_pend_d;
  logic                 par_q, par_d;
  logic                 par_en_q, par_en_d;
  logic                 stop2_q, stop2_d;

  logic                 push, pop, bit_end, odd;
  logic [DATA_BITS:0]   rd_data;
  logic [DATA_BITS-1:0] word;
  logic                 last;

  assign s_axis_tready = ~fifo_full;
  assign push = s_axis_tvalid & s_axis_tready;
  assign word = rd_data[DATA_BITS-1:0];
  assign last = rd_data[DATA_BITS];
  assign odd  = (cfg_parity == PAR_ODD);

  uart_pkt_fifo #(
    .WIDTH (DATA_BITS + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i ({s_axis_tlast, s_axis_tdata}),
    .pop_i   (pop),
    .rdata_o (rd_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign bit_end = (cnt_q == CW'(DIV - 1));

  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    chk_d      = chk_q;
    chk_pend_d = chk_pend_q;
    par_d      = par_q;
    par_en_d   = par_en_q;
    stop2_d    = stop2_q;
    pop        = 1'b0;

    if (state_q != ST_IDLE)
      cnt_d = bit_end ? '0 : cnt_q + CW'(1);

    unique case (state_q)
      ST_IDLE: begin
        bit_d = '0;
        if (tx_ready && (chk_pend_q || !fifo_empty)) begin
          state_d  = ST_START;
          par_en_d = par_enabled(cfg_parity);
          stop2_d  = cfg_stop2;
          // A pending checksum goes out ahead of any queued word.
          if (chk_pend_q) begin
            shreg_d    = chk_q;
            par_d      = (^chk_q) ^ odd;
            chk_d      = '0;
            chk_pend_d = 1'b0;
          end else begin
            pop     = 1'b1;
            shreg_d = word;
            par_d   = (^word) ^ odd;
            if (last && !cfg_chk_en) begin
              chk_d = '0;
            end else begin
              chk_d      = chk_q ^ word;
              chk_pend_d = last;
            end
          end
        end
      end
      ST_START: begin
        if (bit_end) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (bit_end) begin
          shreg_d = shreg_q >> 1;
          if (bit_q == BW'(DATA_BITS - 1)) begin
            bit_d   = '0;
            state_d = par_en_q ? ST_PARITY : ST_STOP;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (bit_end) begin
          if (stop2_q && bit_q == '0) begin
            bit_d = BW'(1);
          end else begin
            bit_d   = '0;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      chk_q      <= '0;
      chk_pend_q <= 1'b0;
      par_q      <= 1'b0;
      par_en_q   <= 1'b0;
      stop2_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      chk_q      <= chk_d;
      chk_pend_q <= chk_pend_d;
      par_q      <= par_d;
      par_en_q   <= par_en_d;
      stop2_q    <= stop2_d;
    end
  end

  assign tx_busy = (state_q != ST_IDLE);

  always_comb begin
    serial_out = 1'b1;
    unique case (state_q)
      ST_START:  serial_out = 1'b0;
      ST_DATA:   serial_out = shreg_q[0];
      ST_PARITY: serial_out = par_q;
      default:   serial_out = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_packetizer_param.sv
// tb_uart_packetizer_param: directed checks of the UART packetizer.
// Instance A uses defaults (DIV 434); B uses DIV 16, 7 data bits.
module tb_uart_packetizer_param;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tdata;
  logic       tlast, va, vb;
  logic [1:0] par;
  logic       stop2, chken, txr;

  logic       rdy_a, so_a, busy_a, full_a, empty_a;
  logic [4:0] lvl_a;
  logic       rdy_b, so_b, busy_b, full_b, empty_b;
  logic [4:0] lvl_b;

  logic       sel;
  logic       line, busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign line = sel ? so_b : so_a;
  assign busy = sel ? busy_b : busy_a;

  uart_packetizer_param u_a (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tdata  (tdata),
    .s_axis_tvalid (va),
    .s_axis_tlast  (tlast),
    .s_axis_tready (rdy_a),
    .cfg_parity    (par),
    .cfg_stop2     (stop2),
    .cfg_chk_en    (chken),
    .tx_ready      (txr),
    .serial_out    (so_a),
    .tx_busy       (busy_a),
    .fifo_full     (full_a),
    .fifo_empty    (empty_a),
    .fifo_level    (lvl_a)
  );

  uart_packetizer_param #(
    .CLK_FREQ   (160),
    .BAUD_RATE  (10),
    .DATA_BITS  (7),
    .FIFO_DEPTH (16)
  ) u_b (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tdata  (tdata[6:0]),
    .s_axis_tvalid (vb),
    .s_axis_tlast  (tlast),
    .s_axis_tready (rdy_b),
    .cfg_parity    (par),
    .cfg_stop2     (stop2),
    .cfg_chk_en    (chken),
    .tx_ready      (txr),
    .serial_out    (so_b),
    .tx_busy       (busy_b),
    .fifo_full     (full_b),
    .fifo_empty    (empty_b),
    .fifo_level    (lvl_b)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic s, input logic [7:0] d,
                      input logic l);
    tdata = d;
    tlast = l;
    if (s) vb = 1'b1;
    else   va = 1'b1;
    @(negedge clk);
    va = 1'b0;
    vb = 1'b0;
  endtask

  // Waits (bounded) for a start bit, then samples every cycle of
  // nbits bit periods; any change inside a period flags bad.
  task automatic recv(input int nbits, output logic [15:0] v,
                      output int bc, output logic bad,
                      output logic to);
    int n;
    int dv;
    n   = 0;
    dv  = sel ? 16 : 434;
    v   = '0;
    bc  = 0;
    bad = 1'b0;
    to  = 1'b0;
    while (line !== 1'b0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (line !== 1'b0) begin
      to = 1'b1;
      return;
    end
    for (int i = 0; i < nbits; i++) begin
      for (int c = 0; c < dv; c++) begin
        if (c == 0) v[i] = line;
        else if (line !== v[i]) bad = 1'b1;
        if (busy === 1'b1) bc++;
        @(negedge clk);
      end
    end
    if (line !== 1'b1 || busy !== 1'b0) bad = 1'b1;
  endtask

  task automatic frame(input string tag, input int nbits,
                       input logic [15:0] ev);
    logic [15:0] v;
    int          bc;
    logic        bad, to;
    recv(nbits, v, bc, bad, to);
    check({tag, "_timeout"}, 32'(to), 32'd0);
    check({tag, "_bits"}, 32'(v), 32'(ev));
    check({tag, "_hold"}, 32'(bad), 32'd0);
    check({tag, "_busy"}, 32'(bc), 32'(nbits * (sel ? 16 : 434)));
  endtask

  initial begin
    int n;
    int cnt;
    rst_n = 1'b0;
    va    = 1'b0;
    vb    = 1'b0;
    tdata = '0;
    tlast = 1'b0;
    par   = 2'b00;
    stop2 = 1'b0;
    chken = 1'b0;
    txr   = 1'b1;
    sel   = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_serial", 32'(so_a), 32'd1);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_level", 32'(lvl_a), 32'd0);
    check("rst_empty", 32'(empty_a), 32'd1);
    check("rst_full", 32'(full_a), 32'd0);
    check("rst_tready", 32'(rdy_a), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // 8N1 0x55
    push(1'b0, 8'h55, 1'b1);
    frame("a_8n1_55", 10, 16'h02AA);

    // even / odd parity on 0x07
    par = 2'b01;
    push(1'b0, 8'h07, 1'b1);
    frame("a_even_07", 11, 16'h060E);
    par = 2'b10;
    push(1'b0, 8'h07, 1'b1);
    frame("a_odd_07", 11, 16'h040E);
    par = 2'b00;

    // FIFO fill / drain on B
    sel = 1'b1;
    txr = 1'b0;
    for (int i = 0; i < 16; i++)
      push(1'b1, 8'(i), (i == 15));
    check("b_full", 32'(full_b), 32'd1);
    check("b_tready", 32'(rdy_b), 32'd0);
    check("b_level16", 32'(lvl_b), 32'd16);
    push(1'b1, 8'h10, 1'b0);
    check("b_level_after17", 32'(lvl_b), 32'd16);
    txr = 1'b1;
    for (int i = 0; i < 16; i++)
      frame($sformatf("b_fifo%0d", i), 9,
            16'h100 | (16'(i) << 1));
    check("b_empty_end", 32'(empty_b), 32'd1);

    // checksum packet 0x12, 0x34(last) -> 0x26
    chken = 1'b1;
    push(1'b1, 8'h12, 1'b0);
    push(1'b1, 8'h34, 1'b1);
    frame("b_chk_12", 9, 16'h0124);
    frame("b_chk_34", 9, 16'h0168);
    frame("b_chk_26", 9, 16'h014C);
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      if (so_b !== 1'b1 || busy_b !== 1'b0) cnt++;
      @(negedge clk);
    end
    check("b_chk_idle", 32'(cnt), 32'd0);
    chken = 1'b0;

    // 7 data bits, two stop bits, back-to-back words
    stop2 = 1'b1;
    txr   = 1'b0;
    push(1'b1, 8'h41, 1'b0);
    push(1'b1, 8'h15, 1'b0);
    txr = 1'b1;
    frame("b_s2_41", 10, 16'h0382);
    n = 0;
    while (so_b === 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("b_idle_gap", 32'(n), 32'd1);
    frame("b_s2_15", 10, 16'h032A);
    stop2 = 1'b0;

    // reset during DATA bit 3 with 3 words queued
    sel = 1'b0;
    txr = 1'b0;
    push(1'b0, 8'hA5, 1'b0);
    push(1'b0, 8'h11, 1'b0);
    push(1'b0, 8'h22, 1'b0);
    push(1'b0, 8'h33, 1'b0);
    txr = 1'b1;
    n = 0;
    while (so_a !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("a_rst_start_seen", 32'(so_a), 32'd0);
    repeat (434 * 4 + 200) @(negedge clk);
    check("a_pre_rst_level", 32'(lvl_a), 32'd3);
    check("a_pre_rst_busy", 32'(busy_a), 32'd1);
    rst_n = 1'b0;
    #1;
    check("a_rst_serial", 32'(so_a), 32'd1);
    check("a_rst_busy", 32'(busy_a), 32'd0);
    check("a_rst_level", 32'(lvl_a), 32'd0);
    check("a_rst_empty", 32'(empty_a), 32'd1);
    check("a_rst_tready", 32'(rdy_a), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      if (so_a !== 1'b1 || busy_a !== 1'b0) cnt++;
      @(negedge clk);
    end
    check("a_post_rst_quiet", 32'(cnt), 32'd0);
    check("a_post_rst_level", 32'(lvl_a), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_packetizer_param.md
UART_PACKETIZER_PARAM -- requirements
Module: uart_packetizer_param

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000: input clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115200: line rate; bit period DIV = floor(CLK_FREQ/BAUD_RATE) cycles (434 at defaults).
REQ-003 Parameter DATA_BITS, default 8, legal 5..9: payload bits per frame.
REQ-004 Parameter FIFO_DEPTH, default 16, power of two >= 2: buffered words.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous and active-low.
REQ-007 s_axis_tdata  in  DATA_BITS  payload word.
REQ-008 s_axis_tvalid  in  1  source has word.
REQ-009 s_axis_tlast  in  1  word ends a packet.
REQ-010 s_axis_tready  out  1  block can accept word.
REQ-011 cfg_parity  in  2  00 none, 01 even, 10 odd, 11 reserved (treated as none).
REQ-012 cfg_stop2  in  1  1 = two stop bits, 0 = one.
REQ-013 cfg_chk_en  in  1  1 = append XOR checksum frame after each tlast word.
REQ-014 tx_ready  in  1  downstream permits a new frame start.
REQ-015 serial_out  out  1  UART line, idle high.
REQ-016 tx_busy  out  1  frame on line.
REQ-017 fifo_full  out  1  FIFO holds FIFO_DEPTH words.
REQ-018 fifo_empty  out  1  FIFO holds zero words.
REQ-019 fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy.

Function
REQ-020 Word accepted on rising edge when s_axis_tvalid and s_axis_tready both 1; s_axis_tready = !fifo_full.
REQ-021 FIFO stores {tlast, tdata}, first-in first-out; pop and push in same cycle allowed, level unchanged.
REQ-022 FSM states IDLE, START, DATA, PARITY, STOP, each non-IDLE bit held exactly DIV cycles.
REQ-023 IDLE -> START when FIFO non-empty (or checksum pending) and tx_ready=1; word popped that cycle, cfg_* latched that cycle and held for the frame.
REQ-024 serial_out low from cycle after pop; DATA sends LSB first, DATA_BITS bits; PARITY only if latched parity even/odd; STOP sends 1 for one or two bit periods.
REQ-025 Even parity bit = XOR of data bits; odd = its inverse.
REQ-026 After final stop bit FSM returns to IDLE for exactly one cycle minimum before the next START.
REQ-027 tx_busy = 1 in all states except IDLE; serial_out = 1 in IDLE.
REQ-028 tx_ready sampled only in IDLE; deassertion mid-frame does not truncate the frame.
REQ-029 Running checksum = XOR of all DATA_BITS payload words popped since last packet end; clears after checksum frame sent or, with cfg_chk_en=0, on tlast word.
REQ-030 With latched cfg_chk_en=1, after a tlast word's frame, next frame is the checksum, sent before any FIFO word, subject to tx_ready.
REQ-031 Baud counter and bit counter wrap to 0 at end of each bit/frame; no residue carries between frames.

Reset
REQ-032 rst_n low immediately forces: FSM IDLE, FIFO empty (fifo_level 0, fifo_empty 1, fifo_full 0), s_axis_tready 1, serial_out 1, tx_busy 0, checksum 0, counters 0.
REQ-033 Reset mid-frame aborts the frame; buffered words are discarded.

Structure
REQ-034 Package uart_pkt_pkg holds parity-mode encoding constants and FSM state encoding.
REQ-035 FIFO is sub-module uart_pkt_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/level); remainder in top.

Verification
REQ-036 Defaults, 8N1, push 0x55 -> serial_out 0,1,0,1,0,1,0,1,0,1 each 434 cycles, tx_busy high 4340 cycles.
REQ-037 cfg_parity=01, push 0x07 -> parity bit 1; cfg_parity=10 -> parity bit 0; frame 11 bit periods.
REQ-038 tx_ready=0, push 17 words 0x00..0x10 -> after 16, fifo_full=1, s_axis_tready=0, level 16; tx_ready=1 -> 0x00..0x0F sent in order, fifo_empty=1 at end.
REQ-039 cfg_chk_en=1, push 0x12, 0x34(tlast) -> frames 0x12, 0x34, 0x26, then line idle.
REQ-040 DATA_BITS=7, cfg_stop2=1, push 0x41 -> 7 data bits then two stop periods; next word start bit follows one idle cycle.
REQ-041 rst_n low during DATA bit 3 with 3 words queued -> serial_out 1, tx_busy 0, fifo_level 0 same cycle; no frame after release.
